dram_master: RTL and testbench
==============================

# dram_master

Initiator side of the DLX data-memory bus: converts single-word load/store requests from the core's memory stage into ADDRESS/ENABLE/READNOTWRITE transactions on the shared bidirectional data bus, waits for DATA_READY, and returns read data or a completion pulse. It sits between the DLX memory stage and the DRAM responder. A bounded wait counter flags responders that never answer.

## Interface
- ADDRESS_SIZE, 16, address width in bits
- WORD_SIZE, 32, data word width in bits
- TIMEOUT, 15, max ACCESS cycles before error; legal range 2..255

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- req_i  in  1  core request, sampled only in IDLE
- rnw_i  in  1  1 = read (load), 0 = write (store)
- addr_i  in  ADDRESS_SIZE  word address
- wdata_i  in  WORD_SIZE  store data
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse, access completed
- err_o  out  1  one-cycle pulse, timeout
- rdata_o  out  WORD_SIZE  last read data, held until next successful read
- ADDRESS  out  ADDRESS_SIZE  bus address
- ENABLE  out  1  bus access strobe
- READNOTWRITE  out  1  bus direction
- DATA_READY  in  1  responder completion
- INOUT_DATA  inout  WORD_SIZE  bidirectional data bus

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE: ENABLE=0, READNOTWRITE=1, INOUT_DATA=Z. If req_i=1, register addr_i, rnw_i and wdata_i, clear wait counter, go to ACCESS. If req_i=0, stay.
- ACCESS: ENABLE=1, ADDRESS and READNOTWRITE come from registers. On a write, INOUT_DATA carries the registered wdata. On a read, INOUT_DATA=Z. The counter increments every ACCESS cycle.
- DATA_READY is ignored on the first ACCESS edge, because the responder only samples ENABLE there. This also masks a stale high level from the previous access.
- From the second ACCESS edge on, DATA_READY=1 ends the access: on a read, capture INOUT_DATA into rdata_o; then go to DONE.
- If the counter reaches TIMEOUT with no accepted DATA_READY, go to ERR.
- DONE: done_o=1, ENABLE=0, bus=Z, next state IDLE.
- ERR: err_o=1, ENABLE=0, bus=Z, rdata_o unchanged, next state IDLE.
- req_i outside IDLE is ignored; it is not queued.
- Rule: INOUT_DATA is driven only while ENABLE=1 and READNOTWRITE=0. It is never driven in the same cycle that READNOTWRITE=1.
- Registered inputs are frozen for the whole transaction. Changes on addr_i, wdata_i or rnw_i mid-access have no effect.

## Timing
- Reset values: state IDLE, ENABLE=0, READNOTWRITE=1, ADDRESS=0, INOUT_DATA=Z, busy_o=0, done_o=0, err_o=0, rdata_o=0, counter=0.
- rst asserted mid-ACCESS: ENABLE drops and the bus releases on the next edge. No done_o or err_o pulse is produced.
- Edge 0: req_i sampled. Cycle 1: ENABLE=1. Edge 1: DATA_READY ignored. Edge 2: earliest accepted DATA_READY. Cycle 3: done_o=1. Edge 3: back to IDLE.
- Minimum latency from req_i to done_o is 3 cycles. Minimum request spacing is 4 cycles.
- Timeout: err_o is high in cycle TIMEOUT+2 after the req_i edge, when DATA_READY stays 0 throughout.
- DATA_READY=1 on the same edge where the counter hits TIMEOUT: completion wins and the state goes to DONE.
- The counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.

## Structure
- Package dram_master_pkg holds the state enum typedef (dram_state_t) and localparam widths derived from TIMEOUT.
- Sub-module dram_bus_drv is natural: the tristate driver for INOUT_DATA plus the read-capture register, with inputs drive_en, wdata and capture_en.
- The FSM and counter stay in dram_master.

## Test plan
- Read, responder ready after 2 cycles, memory[0x0010]=0xDEADBEEF, req_i at edge 0 -> done_o in cycle 3, rdata_o=0xDEADBEEF, INOUT_DATA never driven by master.
- Write 0xCAFEF00D to 0x0020 -> INOUT_DATA=0xCAFEF00D only while ENABLE=1; responder memory[0x0020] updated; done_o one pulse.
- Responder holds DATA_READY=1 from the previous access -> first ACCESS edge ignored, done_o still in cycle 3, not cycle 2.
- Responder silent, TIMEOUT=4 -> err_o in cycle 6, rdata_o unchanged, ENABLE=0 afterwards.
- req_i held high during a transaction plus addr_i toggling -> exactly one access at the originally registered address; next access starts only after IDLE.
- rst pulsed in the second ACCESS cycle -> next cycle ENABLE=0, INOUT_DATA=Z, no done_o or err_o, all outputs at reset values.

Source files
------------

// File: rtl/dram_master_pkg.sv
// dram_master_pkg: shared types and constants for the DLX data-memory bus initiator.
//   dram_state_t      - transaction FSM state encoding
//   ADDRESS_SIZE_DEF  - default bus address width
//   WORD_SIZE_DEF     - default data word width
//   TIMEOUT_DEF       - default ACCESS wait bound (legal 2..255)
//   cnt_width()       - wait-counter width that holds 0..TIMEOUT
package dram_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } dram_state_t;

  localparam int ADDRESS_SIZE_DEF = 16;
  localparam int WORD_SIZE_DEF    = 32;
  localparam int TIMEOUT_DEF      = 15;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/dram_master_if.sv
// dram_master_if: core-side request/response bundle of the data-memory initiator.
//   req_i    - single-word access request (sampled only while the initiator is idle)
//   rnw_i    - 1 = load, 0 = store
//   addr_i   - word address
//   wdata_i  - store data
//   busy_o   - initiator is not idle
//   done_o   - one-cycle completion pulse
//   err_o    - one-cycle timeout pulse
//   rdata_o  - last successfully loaded word
// modport master: the DLX memory stage; modport slave: dram_master.
interface dram_master_if
  import dram_master_pkg::*;
#(
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int WORD_SIZE    = WORD_SIZE_DEF
);

  logic                    req_i;
  logic                    rnw_i;
  logic [ADDRESS_SIZE-1:0] addr_i;
  logic [WORD_SIZE-1:0]    wdata_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    err_o;
  logic [WORD_SIZE-1:0]    rdata_o;

  modport master (
    output req_i, rnw_i, addr_i, wdata_i,
    input  busy_o, done_o, err_o, rdata_o
  );

  modport slave (
    input  req_i, rnw_i, addr_i, wdata_i,
    output busy_o, done_o, err_o, rdata_o
  );

endinterface

// File: rtl/dram_bus_drv.sv
// dram_bus_drv: tristate driver for the shared data bus plus the load-data register.
//   clk, rst    - clock and synchronous active-high reset
//   drive_en    - drive wdata onto bus (store in progress)
//   wdata       - registered store word
//   capture_en  - latch bus into rdata on this edge (accepted load)
//   rdata       - last captured load word, cleared by reset
//   bus         - bidirectional data bus, released (Z) when drive_en is low
module dram_bus_drv
  import dram_master_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 drive_en,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 capture_en,
  output logic [WORD_SIZE-1:0] rdata,
  inout  wire  [WORD_SIZE-1:0] bus
);

  assign bus = drive_en ? wdata : {WORD_SIZE{1'bz}};

  // capture stage: load data is held until the next accepted load
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (capture_en) begin
      rdata <= bus;
    end
  end

endmodule

// File: rtl/dram_master.sv
// dram_master: initiator side of the DLX data-memory bus.
// Turns one core load/store request into an ENABLE/READNOTWRITE/ADDRESS access
// on the shared bus, waits for DATA_READY and reports done_o (or err_o when the
// responder stays silent past TIMEOUT wait cycles).
//   clk, rst      - clock, synchronous active-high reset
//   core          - core-side request/response bundle (dram_master_if.slave)
//   ADDRESS       - registered bus address
//   ENABLE        - bus access strobe, high only during ACCESS
//   READNOTWRITE  - bus direction, 1 whenever not actively storing
//   DATA_READY    - responder completion
//   INOUT_DATA    - bidirectional data bus, driven only during a store
// TIMEOUT must lie in 2..255.
module dram_master
  import dram_master_pkg::*;
#(
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  dram_master_if.slave            core,
  output logic [ADDRESS_SIZE-1:0] ADDRESS,
  output logic                    ENABLE,
  output logic                    READNOTWRITE,
  input  logic                    DATA_READY,
  inout  wire  [WORD_SIZE-1:0]    INOUT_DATA
);

  localparam int               CNT_W     = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Wait counter never wraps: a wrapped value would re-open the first-edge mask.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  dram_state_t             state_p0;
  dram_state_t             state_nxt;
  logic [ADDRESS_SIZE-1:0] addr_p0;
  logic [WORD_SIZE-1:0]    wdata_p0;
  logic                    rnw_p0;
  logic [CNT_W-1:0]        cnt_p0;

  logic                    accept;
  logic                    timed_out;
  logic                    start;
  logic                    drive_en;
  logic                    capture_en;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [WORD_SIZE-1:0]    rdata;

  assign start     = (state_p0 == ST_IDLE) && core.req_i;
  // cnt_p0 is still 0 on the first ACCESS edge, where the responder is only
  // sampling ENABLE; any DATA_READY seen there is stale and must be ignored.
  assign accept    = DATA_READY && (cnt_p0 != '0);
  assign timed_out = (cnt_p0 >= CNT_LIMIT);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // next-state logic; completion takes priority over timeout on the same edge
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_IDLE: begin
        if (core.req_i) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (accept) begin
          state_nxt = ST_DONE;
        end else if (timed_out) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // request stage: fields frozen from the accepting IDLE edge to the end of the access
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p0 <= '0;
      rnw_p0  <= 1'b1;
      cnt_p0  <= '0;
    end else if (start) begin
      addr_p0 <= core.addr_i;
      rnw_p0  <= core.rnw_i;
      cnt_p0  <= '0;
    end else if (state_p0 == ST_ACCESS) begin
      cnt_p0  <= sat_inc(cnt_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      wdata_p0 <= core.wdata_i;
    end
  end

  // output decode; the bus is driven only while ENABLE=1 and READNOTWRITE=0
  always_comb begin
    ENABLE       = 1'b0;
    READNOTWRITE = 1'b1;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    drive_en     = 1'b0;
    capture_en   = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ACCESS: begin
        ENABLE       = 1'b1;
        READNOTWRITE = rnw_p0;
        drive_en     = !rnw_p0;
        capture_en   = rnw_p0 && accept;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      ST_ERR: begin
        err = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign ADDRESS      = addr_p0;
  assign core.busy_o  = busy;
  assign core.done_o  = done;
  assign core.err_o   = err;
  assign core.rdata_o = rdata;

  dram_bus_drv #(
    .WORD_SIZE (WORD_SIZE)
  ) u_bus_drv (
    .clk        (clk),
    .rst        (rst),
    .drive_en   (drive_en),
    .wdata      (wdata_p0),
    .capture_en (capture_en),
    .rdata      (rdata),
    .bus        (INOUT_DATA)
  );

endmodule

// File: tb/tb_dram_master.sv
// tb_dram_master: bench for dram_master with a DRAM responder and a
// transaction-level reference model (outcome and cycle timing computed from the
// responder latency and TIMEOUT, memory contents kept in a shadow array).
module tb_dram_master;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [15:0] ADDRESS;
  logic        ENABLE;
  logic        READNOTWRITE;
  logic        DATA_READY;
  tri0  [31:0] INOUT_DATA;

  dram_master_if #(.ADDRESS_SIZE(16), .WORD_SIZE(32)) core_if ();

  dram_master #(
    .ADDRESS_SIZE (16),
    .WORD_SIZE    (32),
    .TIMEOUT      (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core         (core_if),
    .ADDRESS      (ADDRESS),
    .ENABLE       (ENABLE),
    .READNOTWRITE (READNOTWRITE),
    .DATA_READY   (DATA_READY),
    .INOUT_DATA   (INOUT_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // responder knobs (set from the stimulus side at negedge)
  int          resp_lat    = 1;
  bit          resp_silent = 1'b0;
  bit          resp_sticky = 1'b0;
  int          ecnt;
  logic        resp_drive;
  logic [31:0] resp_data;
  logic [31:0] mem       [0:255];
  logic [31:0] model_mem [0:255];
  logic [31:0] prev_rdata;

  assign INOUT_DATA = resp_drive ? resp_data : 32'bz;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h13570000;
  endfunction

  // DRAM responder: asserts DATA_READY after resp_lat ENABLE edges
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      ecnt       <= 0;
      DATA_READY <= 1'b0;
      resp_drive <= 1'b0;
      resp_data  <= '0;
    end else if (!ENABLE) begin
      ecnt       <= 0;
      resp_drive <= 1'b0;
      if (!resp_sticky) DATA_READY <= 1'b0;
    end else begin
      ecnt <= ecnt + 1;
      if (!resp_silent && (ecnt + 1 == resp_lat)) begin
        DATA_READY <= 1'b1;
        if (READNOTWRITE) begin
          resp_drive <= 1'b1;
          resp_data  <= mem[ADDRESS[7:0]];
        end else begin
          mem[ADDRESS[7:0]] <= INOUT_DATA;
        end
      end else if (ecnt == 0) begin
        DATA_READY <= 1'b0;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    prev_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (ENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%b exp=0", ENABLE); end
    n_tests++; if (READNOTWRITE !== 1'b1) begin n_fail++; $display("FAIL reset_rnw got=%b exp=1", READNOTWRITE); end
    n_tests++; if (ADDRESS !== 16'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", ADDRESS); end
    n_tests++; if ({core_if.busy_o, core_if.done_o, core_if.err_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {core_if.busy_o, core_if.done_o, core_if.err_o}); end
    n_tests++; if (core_if.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", core_if.rdata_o); end
    n_tests++; if (INOUT_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_bus got=%h exp=released", INOUT_DATA); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One transaction; expected timing derived from responder latency and TIMEOUT.
  task automatic run_txn(input logic rnw, input logic [15:0] a, input logic [31:0] wd,
                         input int lat, input bit silent, input bit sticky, input string tag);
    bit          ok;
    int          endc;
    logic [31:0] exp_r;
    logic [31:0] exp_bus;
    ok    = !silent && (lat <= TO);
    endc  = ok ? lat + 2 : TO + 2;
    exp_r = model_mem[a[7:0]];
    @(negedge clk);
    resp_lat = lat; resp_silent = silent; resp_sticky = sticky;
    core_if.req_i = 1'b1; core_if.rnw_i = rnw; core_if.addr_i = a; core_if.wdata_i = wd;
    @(posedge clk); #1;
    core_if.req_i   = 1'b0;
    core_if.addr_i  = 16'($urandom);
    core_if.wdata_i = $urandom;
    core_if.rnw_i   = 1'($urandom);
    for (int k = 1; k <= endc + 1; k++) begin
      n_tests++; if (ENABLE !== (k < endc)) begin
        n_fail++; $display("FAIL %s enable cyc=%0d got=%b exp=%b", tag, k, ENABLE, (k < endc)); end
      n_tests++; if (core_if.busy_o !== (k <= endc)) begin
        n_fail++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, k, core_if.busy_o, (k <= endc)); end
      n_tests++; if (core_if.done_o !== (ok && k == endc)) begin
        n_fail++; $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, k, core_if.done_o, (ok && k == endc)); end
      n_tests++; if (core_if.err_o !== (!ok && k == endc)) begin
        n_fail++; $display("FAIL %s err cyc=%0d got=%b exp=%b", tag, k, core_if.err_o, (!ok && k == endc)); end
      if (k < endc) begin
        n_tests++; if (ADDRESS !== a) begin
          n_fail++; $display("FAIL %s addr cyc=%0d got=%h exp=%h", tag, k, ADDRESS, a); end
        n_tests++; if (READNOTWRITE !== rnw) begin
          n_fail++; $display("FAIL %s rnw cyc=%0d got=%b exp=%b", tag, k, READNOTWRITE, rnw); end
      end else begin
        n_tests++; if (READNOTWRITE !== 1'b1) begin
          n_fail++; $display("FAIL %s rnw_idle cyc=%0d got=%b exp=1", tag, k, READNOTWRITE); end
      end
      if (!rnw && k < endc) exp_bus = wd;
      else if (resp_drive)  exp_bus = exp_r;
      else                  exp_bus = 32'h0;
      n_tests++; if (INOUT_DATA !== exp_bus) begin
        n_fail++; $display("FAIL %s bus cyc=%0d got=%h exp=%h", tag, k, INOUT_DATA, exp_bus); end
      if (k <= endc) begin
        @(posedge clk); #1;
      end
    end
    if (rnw && ok) prev_rdata = exp_r;
    n_tests++; if (core_if.rdata_o !== prev_rdata) begin
      n_fail++; $display("FAIL %s rdata got=%h exp=%h", tag, core_if.rdata_o, prev_rdata); end
    if (!rnw && !silent && lat <= TO + 1) begin
      model_mem[a[7:0]] = wd;
      n_tests++; if (mem[a[7:0]] !== wd) begin
        n_fail++; $display("FAIL %s memwrite got=%h exp=%h", tag, mem[a[7:0]], wd); end
    end
  endtask

  task automatic test_read();
    run_txn(1'b1, 16'h0010, 32'hA5A5F00F, 1, 1'b0, 1'b0, "read");
    n_tests++; if (core_if.rdata_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_value got=%h exp=deadbeef", core_if.rdata_o); end
  endtask

  task automatic test_write();
    run_txn(1'b0, 16'h0020, 32'hCAFEF00D, 1, 1'b0, 1'b0, "write");
    run_txn(1'b1, 16'h0020, 32'h0F0F0F0F, 3, 1'b0, 1'b0, "write_readback");
    n_tests++; if (core_if.rdata_o !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL write_readback_value got=%h exp=cafef00d", core_if.rdata_o); end
  endtask

  task automatic test_stale_ready();
    run_txn(1'b1, 16'h0041, 32'h11111111, 1, 1'b0, 1'b1, "stale_a");
    run_txn(1'b1, 16'h0042, 32'h22222222, 1, 1'b0, 1'b1, "stale_b");
    run_txn(1'b0, 16'h0043, 32'h33333333, 3, 1'b0, 1'b1, "stale_c");
    run_txn(1'b1, 16'h0044, 32'h44444444, 2, 1'b0, 1'b0, "stale_d");
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 16'h0055, 32'h5555AAAA, 1, 1'b1, 1'b0, "timeout_silent");
    run_txn(1'b1, 16'h0056, 32'h0, TO, 1'b0, 1'b0, "timeout_edge_done");
    run_txn(1'b1, 16'h0057, 32'h0, TO + 1, 1'b0, 1'b0, "timeout_edge_err");
    run_txn(1'b0, 16'h0058, 32'h89ABCDEF, TO + 1, 1'b0, 1'b0, "timeout_late_write");
  endtask

  task automatic test_req_hold();
    logic [15:0] a1, a2;
    logic [31:0] w1, w2, exp_bus;
    bit          exp_en, exp_done, exp_busy;
    a1 = 16'h0100 | 16'($urandom_range(0, 127));
    a2 = a1 ^ 16'h0080;
    w1 = $urandom; w2 = $urandom;
    @(negedge clk);
    resp_lat = 1; resp_silent = 1'b0; resp_sticky = 1'b0;
    core_if.req_i = 1'b1; core_if.rnw_i = 1'b0; core_if.addr_i = a1; core_if.wdata_i = w1;
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      exp_en   = (k < 3) || (k >= 5 && k < 7);
      exp_done = (k == 3) || (k == 7);
      exp_busy = (k <= 3) || (k >= 5 && k <= 7);
      exp_bus  = exp_en ? ((k < 5) ? w1 : w2) : 32'h0;
      n_tests++; if (ENABLE !== exp_en) begin
        n_fail++; $display("FAIL hold enable cyc=%0d got=%b exp=%b", k, ENABLE, exp_en); end
      n_tests++; if (core_if.done_o !== exp_done || core_if.err_o !== 1'b0) begin
        n_fail++; $display("FAIL hold done/err cyc=%0d got=%b%b exp=%b0", k, core_if.done_o, core_if.err_o, exp_done); end
      n_tests++; if (core_if.busy_o !== exp_busy) begin
        n_fail++; $display("FAIL hold busy cyc=%0d got=%b exp=%b", k, core_if.busy_o, exp_busy); end
      n_tests++; if (INOUT_DATA !== exp_bus) begin
        n_fail++; $display("FAIL hold bus cyc=%0d got=%h exp=%h", k, INOUT_DATA, exp_bus); end
      if (exp_en) begin
        n_tests++; if (ADDRESS !== ((k < 5) ? a1 : a2)) begin
          n_fail++; $display("FAIL hold addr cyc=%0d got=%h exp=%h", k, ADDRESS, (k < 5) ? a1 : a2); end
      end
      @(negedge clk);
      if (k == 4) begin
        core_if.addr_i = a2; core_if.wdata_i = w2;
      end else begin
        if (k >= 5) core_if.req_i = 1'b0;
        core_if.addr_i  = 16'($urandom);
        core_if.wdata_i = $urandom;
      end
      @(posedge clk); #1;
    end
    model_mem[a1[7:0]] = w1;
    model_mem[a2[7:0]] = w2;
    n_tests++; if (mem[a1[7:0]] !== w1) begin n_fail++; $display("FAIL hold mem1 got=%h exp=%h", mem[a1[7:0]], w1); end
    n_tests++; if (mem[a2[7:0]] !== w2) begin n_fail++; $display("FAIL hold mem2 got=%h exp=%h", mem[a2[7:0]], w2); end
  endtask

  task automatic test_random();
    logic        rnw;
    logic [15:0] a;
    logic [31:0] wd;
    int          lat;
    bit          silent;
    for (int n = 0; n < 30; n++) begin
      rnw    = 1'($urandom);
      a      = 16'($urandom);
      wd     = $urandom;
      lat    = $urandom_range(1, TO + 2);
      silent = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(rnw, a, wd, lat, silent, 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    resp_lat = 3; resp_silent = 1'b0; resp_sticky = 1'b0;
    core_if.req_i = 1'b1; core_if.rnw_i = 1'b1; core_if.addr_i = 16'h0030; core_if.wdata_i = 32'h77777777;
    @(posedge clk); #1;
    core_if.req_i = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (ENABLE !== 1'b1) begin n_fail++; $display("FAIL rstmid pre_enable got=%b exp=1", ENABLE); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (ENABLE !== 1'b0 || READNOTWRITE !== 1'b1) begin
      n_fail++; $display("FAIL rstmid bus_ctrl got=%b%b exp=01", ENABLE, READNOTWRITE); end
    n_tests++; if (ADDRESS !== 16'h0) begin n_fail++; $display("FAIL rstmid addr got=%h exp=0", ADDRESS); end
    n_tests++; if (INOUT_DATA !== 32'h0) begin n_fail++; $display("FAIL rstmid bus got=%h exp=released", INOUT_DATA); end
    n_tests++; if (core_if.rdata_o !== 32'h0) begin n_fail++; $display("FAIL rstmid rdata got=%h exp=0", core_if.rdata_o); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      n_tests++; if ({core_if.busy_o, core_if.done_o, core_if.err_o, ENABLE} !== 4'b0000) begin
        n_fail++; $display("FAIL rstmid flags cyc=%0d got=%b exp=0000", k,
                           {core_if.busy_o, core_if.done_o, core_if.err_o, ENABLE}); end
      @(posedge clk); #1;
    end
    run_txn(1'b1, 16'h0010, 32'h0, 2, 1'b0, 1'b0, "after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    core_if.req_i   = 1'b0;
    core_if.rnw_i   = 1'b1;
    core_if.addr_i  = '0;
    core_if.wdata_i = '0;
    model_reset();
    test_reset();
    test_read();
    test_write();
    test_stale_ready();
    test_timeout();
    test_req_hold();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
